// File: rtl/add_sub_pipe.sv
// Pipelined N-bit adder/subtractor: one W=N/S bit chunk per stage, chunk carry
// registered between stages, valid/ready handshake with a global advance enable.
module add_sub_pipe #(
  parameter int N = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  localparam int W = N / S;

  // Each stage forwards the whole operand word; later stages only look at
  // their own chunk, so unused low bits are trimmed by synthesis.
  logic [S-1:0][N-1:0] a_d, a_q, b_d, b_q, sum_d, sum_q;
  logic [S-1:0]        vld_d, vld_q, c_d, c_q;
  logic                ovf_d, ovf_q;
  logic                adv;

  logic [N-1:0] sa, sb, ss;
  logic         sc, sv;
  logic [W:0]   part;

  assign adv      = !vld_q[S-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    vld_d = vld_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    sa    = '0;
    sb    = '0;
    ss    = '0;
    sc    = 1'b0;
    sv    = 1'b0;
    part  = '0;
    for (int k = 0; k < S; k++) begin
      if (k == 0) begin
        sa = a;
        sb = b ^ {N{sel}};
        sc = cin ^ sel;
        ss = '0;
        sv = in_valid;
      end else begin
        sa = a_q[(k == 0) ? 0 : k-1];
        sb = b_q[(k == 0) ? 0 : k-1];
        sc = c_q[(k == 0) ? 0 : k-1];
        ss = sum_q[(k == 0) ? 0 : k-1];
        sv = vld_q[(k == 0) ? 0 : k-1];
      end
      part = {1'b0, sa[k*W +: W]} + {1'b0, sb[k*W +: W]} + {{W{1'b0}}, sc};
      ss[k*W +: W] = part[W-1:0];
      a_d[k]   = sa;
      b_d[k]   = sb;
      c_d[k]   = part[W];
      sum_d[k] = ss;
      vld_d[k] = sv;
      // carry into the MSB is recovered as a^b^s at that bit
      if (k == S-1) ovf_d = sa[N-1] ^ sb[N-1] ^ part[W-1] ^ part[W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage's operand copies feed nothing downstream.
  logic unused_tail;
  assign unused_tail = ^{a_q[S-1], b_q[S-1]};

  assign out_valid = vld_q[S-1];
  assign sum       = sum_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q;
  assign zero      = (sum_q[S-1] == '0);
  assign neg       = sum_q[S-1][N-1];
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed corner cases, streaming with a stall,
// reset mid-flight, and a parameter sweep against an arithmetic reference.
module tb_add_sub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // main instance, N=32 S=4
  logic rst, in_valid, in_ready, sel, cin, out_valid, out_ready, cout, ovf, zero, neg;
  logic [31:0] a, b, sum;

  add_sub_pipe #(.N(32), .S(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sel(sel), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));

  // sweep instances share one stimulus bus
  logic        sw_rst, sw_valid, sw_sel, sw_cin;
  logic [63:0] sw_a, sw_b;
  logic        r8, r16, r32, r64, v8, v16, v32, v64;
  logic        c8, c16, c32, c64, o8, o16, o32, o64;
  logic        z8, z16, z32, z64, n8, n16, n32, n64;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;

  add_sub_pipe #(.N(8), .S(1)) d8 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(r8), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .sel(sw_sel), .cin(sw_cin), .out_valid(v8), .out_ready(1'b1), .sum(s8),
    .cout(c8), .ovf(o8), .zero(z8), .neg(n8));
  add_sub_pipe #(.N(16), .S(2)) d16 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(r16), .a(sw_a[15:0]), .b(sw_b[15:0]),
    .sel(sw_sel), .cin(sw_cin), .out_valid(v16), .out_ready(1'b1), .sum(s16),
    .cout(c16), .ovf(o16), .zero(z16), .neg(n16));
  add_sub_pipe #(.N(32), .S(8)) d32 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(r32), .a(sw_a[31:0]), .b(sw_b[31:0]),
    .sel(sw_sel), .cin(sw_cin), .out_valid(v32), .out_ready(1'b1), .sum(s32),
    .cout(c32), .ovf(o32), .zero(z32), .neg(n32));
  add_sub_pipe #(.N(64), .S(4)) d64 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(r64), .a(sw_a), .b(sw_b),
    .sel(sw_sel), .cin(sw_cin), .out_valid(v64), .out_ready(1'b1), .sum(s64),
    .cout(c64), .ovf(o64), .zero(z64), .neg(n64));

  // Reference: exact integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [65:0] model(int n, logic [63:0] x, logic [63:0] y, logic s, logic ci);
    logic [63:0] mask;
    logic signed [71:0] ux, uy, sx, sy, uf, r, lim;
    logic cy;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    ux = $signed({8'd0, x & mask});
    uy = $signed({8'd0, y & mask});
    sx = ux;
    sy = uy;
    if (x[n-1]) sx = ux - (72'sd1 << n);
    if (y[n-1]) sy = uy - (72'sd1 << n);
    lim = 72'sd1 << (n-1);
    if (!s) begin
      uf = ux + uy + ci;
      cy = uf[n];
      r  = sx + sy + ci;
    end else begin
      uf = ux - uy - ci;
      cy = (ux >= uy + ci);
      r  = sx - sy - ci;
    end
    return {(r >= lim) || (r < -lim), cy, uf[63:0] & mask};
  endfunction

  task automatic check(string tag, logic [65:0] obs, logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept one op on the main DUT, then wait (bounded) for its result
  task automatic issue_wait(logic [31:0] x, logic [31:0] y, logic s, logic ci, output int lat);
    a = x; b = y; sel = s; cin = ci; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  function automatic logic [65:0] got32();
    return {ovf, cout, 32'd0, sum};
  endfunction

  task automatic sw_chk(string tag, int n, int s, int j, logic ov, logic [65:0] got,
                        logic [63:0] hx, logic [63:0] hy, logic hs, logic hc);
    check({tag, "_valid"}, {65'd0, ov}, {65'd0, (j >= s-1)});
    if (j >= s-1) check({tag, "_res"}, got, model(n, hx, hy, hs, hc));
  endtask

  logic [31:0] st_a [8];
  logic [31:0] st_b [8];
  logic        st_s [8];
  logic        st_c [8];
  logic [65:0] exp_q [$];
  logic [63:0] ha [20];
  logic [63:0] hb [20];
  logic        hs [20];
  logic        hc [20];

  initial begin
    int lat, issued, got, cyc;
    logic acc, take;
    logic [69:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = 1'b0; cin = 1'b0;
    sw_rst = 1'b1; sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sel = 1'b0; sw_cin = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;

    // reset values
    check("rst_out_valid", {65'd0, out_valid}, 66'd0);
    check("rst_sum", {34'd0, sum}, 66'd0);
    check("rst_flags", {62'd0, cout, ovf, zero, neg}, {62'd0, 4'b0010});
    check("rst_in_ready", {65'd0, in_ready}, 66'd1);

    // carry ripples through all chunks
    issue_wait(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check("carry_lat", 66'(lat), 66'd3);
    check("carry_sum", {34'd0, sum}, 66'd0);
    check("carry_flags", {62'd0, cout, ovf, zero, neg}, {62'd0, 4'b1010});
    step();
    check("carry_drain", {65'd0, out_valid}, 66'd0);

    issue_wait(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check("addovf_sum", {34'd0, sum}, {34'd0, 32'h8000_0000});
    check("addovf_flags", {62'd0, cout, ovf, zero, neg}, {62'd0, 4'b0101});
    step();

    issue_wait(32'h8000_0000, 32'h1, 1'b1, 1'b0, lat);
    check("subovf_sum", {34'd0, sum}, {34'd0, 32'h7FFF_FFFF});
    check("subovf_flags", {62'd0, cout, ovf, zero, neg}, {62'd0, 4'b1100});
    step();

    issue_wait(32'd5, 32'd7, 1'b1, 1'b1, lat);
    check("borrow_sum", {34'd0, sum}, {34'd0, 32'hFFFF_FFFD});
    check("borrow_flags", {62'd0, cout, ovf, zero, neg}, {62'd0, 4'b0001});
    step();

    // streaming, out_ready low for cycles 4..6
    for (int i = 0; i < 8; i++) begin
      st_a[i] = $urandom; st_b[i] = $urandom;
      st_s[i] = 1'($urandom); st_c[i] = 1'($urandom);
    end
    issued = 0; got = 0; cyc = 0; held = '0;
    while (got < 8 && cyc < 40) begin
      in_valid  = (issued < 8);
      a   = st_a[issued % 8]; b = st_b[issued % 8];
      sel = st_s[issued % 8]; cin = st_c[issued % 8];
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (cyc >= 4 && cyc <= 6) begin
        check("stall_in_ready", {65'd0, in_ready}, 66'd0);
        if (cyc == 4) held = {out_valid, sum, cout, ovf, zero, neg, 32'd0};
        else check("stall_hold", {out_valid, sum, cout, ovf, zero, neg, 28'd0},
                   {held[69:32], 28'd0});
      end
      if (take) begin
        if (exp_q.size() == 0) check("stream_extra", 66'd1, 66'd0);
        else check("stream_res", got32(), exp_q.pop_front());
        got++;
      end
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(model(32, {32'd0, st_a[issued]}, {32'd0, st_b[issued]},
                              st_s[issued], st_c[issued]));
        issued++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 66'(got), 66'd8);
    exp_q.delete();

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sel = 1'b0; cin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rst_flush_valid", {65'd0, out_valid}, 66'd0);
      step();
    end
    st_a[0] = $urandom; st_b[0] = $urandom;
    issue_wait(st_a[0], st_b[0], 1'b1, 1'b0, lat);
    check("post_rst_lat", 66'(lat), 66'd3);
    check("post_rst_res", got32(), model(32, {32'd0, st_a[0]}, {32'd0, st_b[0]}, 1'b1, 1'b0));
    step();

    // parameter sweep, continuous stream
    sw_rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      ha[j] = {$urandom, $urandom}; hb[j] = {$urandom, $urandom};
      hs[j] = 1'($urandom); hc[j] = 1'($urandom);
      if (j == 5) begin ha[j] = '1; hb[j] = 64'd1; hs[j] = 1'b0; hc[j] = 1'b0; end
      sw_a = ha[j]; sw_b = hb[j]; sw_sel = hs[j]; sw_cin = hc[j]; sw_valid = 1'b1;
      step();
      sw_chk("sw8", 8, 1, j, v8, {o8, c8, 56'd0, s8},
             ha[(j >= 0) ? j : 0], hb[(j >= 0) ? j : 0], hs[(j >= 0) ? j : 0], hc[(j >= 0) ? j : 0]);
      sw_chk("sw16", 16, 2, j, v16, {o16, c16, 48'd0, s16},
             ha[(j >= 1) ? j-1 : 0], hb[(j >= 1) ? j-1 : 0], hs[(j >= 1) ? j-1 : 0], hc[(j >= 1) ? j-1 : 0]);
      sw_chk("sw32", 32, 8, j, v32, {o32, c32, 32'd0, s32},
             ha[(j >= 7) ? j-7 : 0], hb[(j >= 7) ? j-7 : 0], hs[(j >= 7) ? j-7 : 0], hc[(j >= 7) ? j-7 : 0]);
      sw_chk("sw64", 64, 4, j, v64, {o64, c64, s64},
             ha[(j >= 3) ? j-3 : 0], hb[(j >= 3) ? j-3 : 0], hs[(j >= 3) ? j-3 : 0], hc[(j >= 3) ? j-3 : 0]);
    end
    sw_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
